// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response signal bundle between the CPU control path and seq_alu
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] ext_b;
   logic             src_b_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             busy;

   // Requester side: issues operations and consumes results
   modport master (
      output in_valid, alu_op, src_a, reg_b, ext_b, src_b_sel, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, busy
   );

   // ALU side
   modport slave (
      input  in_valid, alu_op, src_a, reg_b, ext_b, src_b_sel, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, busy
   );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: 1-cycle logic/arith ops plus iterative MUL/MULHU/DIVU/REMU
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic      CLK,
   input  logic      RST,
   seq_alu_if.slave  s
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state_q, state_d;
   // MUL: {partial product high, remaining multiplier}; DIV: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // MUL: multiplicand; DIV: divisor
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Selects the upper half of acc at completion (MULHU / REMU share opcode bit 0)
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   b_in;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH-1:0]   q_res;
   logic               q_carry;
   logic               q_ovf;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   assign b_in     = s.src_b_sel ? s.ext_b : s.reg_b;
   assign shamt    = b_in[SHW-1:0];
   assign add_full = {1'b0, s.src_a} + {1'b0, b_in};
   assign sub_full = {1'b0, s.src_a} - {1'b0, b_in};

   // Single-cycle datapath, evaluated on the live request operands
   always_comb begin
      q_res   = '0;
      q_carry = 1'b0;
      q_ovf   = 1'b0;
      case (s.alu_op)
         4'h0: begin
            q_res   = add_full[WIDTH-1:0];
            q_carry = add_full[WIDTH];
            q_ovf   = (s.src_a[WIDTH-1] == b_in[WIDTH-1]) &&
                      (add_full[WIDTH-1] != s.src_a[WIDTH-1]);
         end
         4'h1: begin
            q_res   = sub_full[WIDTH-1:0];
            q_carry = sub_full[WIDTH];
            q_ovf   = (s.src_a[WIDTH-1] != b_in[WIDTH-1]) &&
                      (sub_full[WIDTH-1] != s.src_a[WIDTH-1]);
         end
         4'h2: q_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
         4'h3: q_res = s.src_a >> shamt;
         4'h4: q_res = s.src_a << shamt;
         4'h5: q_res = s.src_a | b_in;
         4'h6: q_res = s.src_a & b_in;
         4'h7: q_res = s.src_a ^ b_in;
         4'h8: q_res = {{(WIDTH-1){1'b0}}, ($signed(s.src_a) < $signed(b_in))};
         4'h9: q_res = $unsigned($signed(s.src_a) >>> shamt);
         default: q_res = '0;
      endcase
   end

   // One shift-add multiply step and one restoring divide step per cycle
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_rem   = div_shift[WIDTH-1:0] - opnd_q;
      div_next  = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
   end

   // Control FSM: next state, iteration datapath and registered result/flags
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (s.in_valid) begin
               hi_d  = s.alu_op[0];
               cnt_d = CW'(WIDTH);
               if (s.alu_op == 4'hA || s.alu_op == 4'hB) begin
                  state_d = MUL;
                  acc_d   = {{WIDTH{1'b0}}, b_in};
                  opnd_d  = s.src_a;
               end else if (s.alu_op == 4'hC || s.alu_op == 4'hD) begin
                  state_d = DIV;
                  acc_d   = {{WIDTH{1'b0}}, s.src_a};
                  opnd_d  = b_in;
               end else begin
                  state_d  = DONE;
                  result_d = q_res;
                  zero_d   = (q_res == '0);
                  carry_d  = q_carry;
                  ovf_d    = q_ovf;
               end
            end
         end
         MUL, DIV: begin
            acc_d = (state_q == MUL) ? mul_next : div_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d  = DONE;
               result_d = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
               zero_d   = (result_d == '0);
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
            end
         end
         DONE: begin
            if (s.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         hi_q     <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign s.in_ready  = (state_q == IDLE);
   assign s.out_valid = (state_q == DONE);
   assign s.busy      = (state_q == MUL) || (state_q == DIV);
   assign s.result    = result_q;
   assign s.zero      = zero_q;
   assign s.carry     = carry_q;
   assign s.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
module tb_seq_alu;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32)) bus ();

   seq_alu #(.WIDTH(32)) dut (
      .CLK (clk),
      .RST (rst_n),
      .s   (bus)
   );

   typedef struct packed {
      logic [31:0] r;
      logic        z;
      logic        c;
      logic        v;
   } res_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
      res_t        exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference behaviour from plain integer arithmetic
   function automatic res_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      res_t        o;
      longint      sa;
      longint      sb;
      longint      sr;
      logic [63:0] p;
      int          sh;
      o  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      p  = 64'(a) * 64'(b);
      case (op)
         4'h0: begin
            o.r = a + b;
            sr  = sa + sb;
            o.c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
            o.v = (sr != longint'($signed(o.r)));
         end
         4'h1: begin
            o.r = a - b;
            sr  = sa - sb;
            o.c = (a < b);
            o.v = (sr != longint'($signed(o.r)));
         end
         4'h2: o.r = (a < b) ? 32'd1 : 32'd0;
         4'h3: o.r = a >> sh;
         4'h4: o.r = a << sh;
         4'h5: o.r = a | b;
         4'h6: o.r = a & b;
         4'h7: o.r = a ^ b;
         4'h8: o.r = (sa < sb) ? 32'd1 : 32'd0;
         4'h9: o.r = 32'($signed(a) >>> sh);
         4'hA: o.r = p[31:0];
         4'hB: o.r = p[63:32];
         4'hC: o.r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'hD: o.r = (b == 0) ? a : a % b;
         default: o.r = '0;
      endcase
      o.z = (o.r == 0);
      return o;
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
      return (op >= 4'hA && op <= 4'hD) ? 33 : 1;
   endfunction

   // Issue one request at a negedge, then collect the response; hold>0 stalls the consumer
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sel, input int hold,
                        output res_t got, output int lat, output int bcnt,
                        output bit stable, output bit dropped);
      int guard;
      bus.alu_op    = op;
      bus.src_a     = a;
      bus.src_b_sel = sel;
      if (sel) begin
         bus.ext_b = b;
         bus.reg_b = $urandom;
      end else begin
         bus.reg_b = b;
         bus.ext_b = $urandom;
      end
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.alu_op    = 4'($urandom);
      bus.src_a     = $urandom;
      bus.reg_b     = $urandom;
      bus.ext_b     = $urandom;
      bus.src_b_sel = 1'($urandom);
      lat  = 1;
      bcnt = 0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      got.r  = bus.result;
      got.z  = bus.zero;
      got.c  = bus.carry;
      got.v  = bus.overflow;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.result !== got.r || bus.zero !== got.z ||
             bus.carry !== got.c || bus.overflow !== got.v)
            stable = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      dropped = !bus.out_valid;
      @(negedge clk);
   endtask

   task automatic run_and_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic sel, input int hold,
                                input res_t exp);
      res_t got;
      int   lat;
      int   bcnt;
      bit   stable;
      bit   dropped;
      do_op(op, a, b, sel, hold, got, lat, bcnt, stable, dropped);
      check($sformatf("%s.result", tag), 64'(got.r), 64'(exp.r));
      check($sformatf("%s.zero", tag), 64'(got.z), 64'(exp.z));
      check($sformatf("%s.carry", tag), 64'(got.c), 64'(exp.c));
      check($sformatf("%s.overflow", tag), 64'(got.v), 64'(exp.v));
      check($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat(op)));
      check($sformatf("%s.busy_cycles", tag), 64'(bcnt), 64'(exp_lat(op) - 1));
      check($sformatf("%s.valid_drop", tag), 64'(dropped), 64'd1);
      if (hold > 0) check($sformatf("%s.stable", tag), 64'(stable), 64'd1);
   endtask

   // Start an iterative op and pull reset low while it is still running
   task automatic reset_mid(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int after);
      int guard;
      bus.alu_op    = op;
      bus.src_a     = a;
      bus.reg_b     = b;
      bus.src_b_sel = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (after - 1) @(negedge clk);
      check($sformatf("%s.busy_before", tag), 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check($sformatf("%s.out_valid", tag), 64'(bus.out_valid), 64'd0);
      check($sformatf("%s.busy", tag), 64'(bus.busy), 64'd0);
      check($sformatf("%s.result", tag), 64'(bus.result), 64'd0);
      check($sformatf("%s.zero", tag), 64'(bus.zero), 64'd0);
      check($sformatf("%s.carry", tag), 64'(bus.carry), 64'd0);
      check($sformatf("%s.overflow", tag), 64'(bus.overflow), 64'd0);
      check($sformatf("%s.in_ready", tag), 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      vec_t vt[$];
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
      int          hold;

      vt.push_back('{4'h0, 32'h7FFF_FFFF, 32'h1,         1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b1}});
      vt.push_back('{4'h1, 32'h5,         32'h5,         1'b0, '{32'h0,         1'b1, 1'b0, 1'b0}});
      vt.push_back('{4'h1, 32'h3,         32'h5,         1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0}});
      vt.push_back('{4'h8, 32'hFFFF_FFFF, 32'h1,         1'b0, '{32'h1,         1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'h2, 32'hFFFF_FFFF, 32'h1,         1'b0, '{32'h0,         1'b1, 1'b0, 1'b0}});
      vt.push_back('{4'h9, 32'h8000_0000, 32'h21,        1'b1, '{32'hC000_0000, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'h4, 32'h1,         32'd31,        1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'h3, 32'hF000_0000, 32'h24,        1'b0, '{32'h0F00_0000, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'h1, 32'h8000_0000, 32'h1,         1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1}});
      vt.push_back('{4'h0, 32'hFFFF_FFFF, 32'h1,         1'b0, '{32'h0,         1'b1, 1'b1, 1'b0}});
      vt.push_back('{4'h5, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0, '{32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'h6, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, '{32'h0F00_0F00, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'h7, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, '{32'h0,         1'b1, 1'b0, 1'b0}});
      vt.push_back('{4'hE, 32'h1234_5678, 32'h9,         1'b0, '{32'h0,         1'b1, 1'b0, 1'b0}});
      vt.push_back('{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h0,         1'b1, 1'b0, 1'b0}});
      vt.push_back('{4'hA, 32'hFFFF_FFFF, 32'h2,         1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'hB, 32'hFFFF_FFFF, 32'h2,         1'b1, '{32'h1,         1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'hC, 32'd100,       32'd7,         1'b0, '{32'd14,        1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'hD, 32'd100,       32'd7,         1'b1, '{32'd2,         1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'hC, 32'd9,         32'd0,         1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'hD, 32'd9,         32'd0,         1'b0, '{32'd9,         1'b0, 1'b0, 1'b0}});
      vt.push_back('{4'hD, 32'd21,        32'd7,         1'b0, '{32'd0,         1'b1, 1'b0, 1'b0}});

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_op    = 4'h0;
      bus.src_a     = '0;
      bus.reg_b     = '0;
      bus.ext_b     = '0;
      bus.src_b_sel = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.out_valid", 64'(bus.out_valid), 64'd0);
      check("reset.busy", 64'(bus.busy), 64'd0);
      check("reset.in_ready", 64'(bus.in_ready), 64'd1);
      check("reset.result", 64'(bus.result), 64'd0);
      check("reset.flags", 64'({bus.zero, bus.carry, bus.overflow}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vt.size(); i++)
         run_and_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].sel, 0, vt[i].exp);

      // Consumer stalls for five cycles on a divide and on a 1-cycle op
      run_and_check("hold_divu", 4'hC, 32'd100, 32'd7, 1'b0, 5, '{32'd14, 1'b0, 1'b0, 1'b0});
      run_and_check("hold_sub", 4'h1, 32'd3, 32'd5, 1'b0, 5, '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0});

      // Reset mid-divide with all flags previously set, then a fresh ADD
      run_and_check("preflags", 4'h0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, '{32'h0, 1'b1, 1'b1, 1'b1});
      reset_mid("rst_div", 4'hC, 32'd100, 32'd7, 10);
      run_and_check("post_rst_add", 4'h0, 32'd2, 32'd3, 1'b0, 0, '{32'd5, 1'b0, 1'b0, 1'b0});

      // Reset mid-multiply with a non-zero result held
      run_and_check("preresult", 4'h1, 32'd3, 32'd5, 1'b0, 0, '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0});
      reset_mid("rst_mul", 4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 10);
      run_and_check("post_rst_mul", 4'hA, 32'd6, 32'd7, 1'b0, 0, '{32'd42, 1'b0, 1'b0, 1'b0});

      // Random operations against the reference model
      for (int n = 0; n < 200; n++) begin
         op  = 4'($urandom_range(0, 15));
         a   = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 40));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 3));
         sel  = 1'($urandom);
         hold = $urandom_range(0, 2);
         run_and_check($sformatf("rnd%0d_op%0h", n, op), op, a, b, sel, hold, ref_alu(op, a, b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
